// File: rtl/wiphy_pkg.sv
// Shared types and helpers for the frame capture datapath.
package wiphy_pkg;

  typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

  // |I|+|Q| of two WIDTH-bit signed values needs one extra bit.
  function automatic int unsigned mag_width(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage; head entry is read straight from the storage registers.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // Full is judged on the current count, so a same-cycle read never makes room for a write.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_sync.sv
// Triggered multi-channel ADC frame capture, buffered and serialised onto an AXI-Stream port.
module frame_sync
  import wiphy_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LEN_W    = 16,
  localparam int unsigned UW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [LEN_W-1:0]             frame_len,
  input  logic                         adc_valid,
  input  logic [CHANNELS*2*WIDTH-1:0]  adc_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2*WIDTH-1:0]           m_data,
  output logic [UW-1:0]                m_user,
  output logic                         m_last,
  output logic                         overflow,
  output logic                         irq
);

  localparam int unsigned MagW = mag_width(WIDTH);
  localparam int unsigned VecW = CHANNELS * 2 * WIDTH;
  localparam int unsigned EntW = VecW + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, len_eff;
  logic [UW-1:0]    chan_q;
  logic             overflow_q, irq_q;
  logic [WIDTH-1:0] abs_i, abs_q;
  logic [MagW-1:0]  mag;
  logic             hit, wr_req, wr_en, wr_last, full, empty;
  logic             beat_hs, pop, last_hs, last_chan;
  logic [EntW-1:0]  rd_entry;

  // Magnitude of channel 0; the most negative value maps to 2^(WIDTH-1) without saturation.
  assign abs_i = adc_data[WIDTH-1] ? (~adc_data[WIDTH-1:0] + WIDTH'(1)) : adc_data[WIDTH-1:0];
  assign abs_q = adc_data[2*WIDTH-1] ? (~adc_data[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                     : adc_data[2*WIDTH-1:WIDTH];
  assign mag     = {1'b0, abs_i} + {1'b0, abs_q};
  assign hit     = enable && adc_valid && (mag > {1'b0, threshold});
  assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;

  assign wr_en     = wr_req && !full;
  assign last_chan = (chan_q == UW'(CHANNELS - 1));
  assign beat_hs   = m_valid && m_ready;
  assign pop       = beat_hs && last_chan;
  assign last_hs   = beat_hs && m_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (hit && !full) state_d = (len_eff == LEN_W'(1)) ? StDrain : StCapture;
      StCapture: if (adc_valid && !full && wr_last) state_d = StDrain;
      StDrain:   if (last_hs) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Write control and frame bookkeeping; dropped samples leave the sample count untouched.
  always_comb begin
    wr_req  = 1'b0;
    wr_last = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        wr_req  = hit;
        wr_last = (len_eff == LEN_W'(1));
        if (hit && !full) begin
          len_d = len_eff;
          cnt_d = LEN_W'(1);
        end
      end
      StCapture: begin
        wr_req  = adc_valid;
        wr_last = ((cnt_q + LEN_W'(1)) == len_q);
        if (adc_valid && !full) cnt_d = cnt_q + LEN_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    m_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_q == UW'(k)) m_data = rd_entry[k*2*WIDTH +: 2*WIDTH];
    end
  end

  assign m_valid  = !empty;
  assign m_user   = chan_q;
  assign m_last   = !empty && rd_entry[VecW] && last_chan;
  assign overflow = overflow_q;
  assign irq      = irq_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q      <= '0;
      cnt_q      <= '0;
      chan_q     <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (wr_req && full);
      irq_q      <= last_hs;
      if (beat_hs) chan_q <= pop ? '0 : chan_q + UW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (wr_en),
    .wr_data ({wr_last, adc_data}),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: threshold table plus multi-cycle frame, stall, overflow and reset cases.
module tb_frame_sync;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = 16;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              enable = 1'b0;
  logic [W-1:0]      threshold = '0;
  logic [LW-1:0]     frame_len = '0;
  logic              adc_valid = 1'b0;
  logic [CH*2*W-1:0] adc_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [2*W-1:0]    m_data;
  logic [0:0]        m_user;
  logic              m_last;
  logic              overflow;
  logic              irq;

  frame_sync #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEPTH    (D),
    .LEN_W    (LW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (enable),
    .threshold (threshold),
    .frame_len (frame_len),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_user    (m_user),
    .m_last    (m_last),
    .overflow  (overflow),
    .irq       (irq)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  typedef struct {
    int i0;
    int q0;
    int thr;
    bit en;
    bit trig;
  } vec_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          beats = 0;
  int          rdy_mode = 1;
  logic        stall = 1'b0;
  logic        exp_irq = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_user = 1'b0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Mid-cycle observation of the output port; a handshake seen here completes at the next edge.
  task automatic monitor();
    beat_t e;
    if (!aresetn) begin
      stall   = 1'b0;
      exp_irq = 1'b0;
      return;
    end
    if (irq || exp_irq) chk("irq", irq, exp_irq);
    if (stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_user", m_user, prev_user);
      chk("stall_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e.data);
        chk("beat_user", m_user, e.user);
        chk("beat_last", m_last, e.last);
      end
    end
    exp_irq   = m_valid && m_ready && m_last;
    stall     = m_valid && !m_ready;
    prev_data = m_data;
    prev_user = m_user;
    prev_last = m_last;
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    m_ready  = (mode != 0);
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    if (rdy_mode == 2) m_ready = ~m_ready;
    else               m_ready = (rdy_mode == 1);
  endtask

  task automatic send(input int i0, input int q0, input int i1, input int q1,
                      input bit wr, input bit fin);
    beat_t b;
    adc_data  = {16'(q1), 16'(i1), 16'(q0), 16'(i0)};
    adc_valid = 1'b1;
    step();
    if (wr) begin
      b.data = {16'(q0), 16'(i0)};
      b.user = 1'b0;
      b.last = 1'b0;
      exp_q.push_back(b);
      b.data = {16'(q1), 16'(i1)};
      b.user = 1'b1;
      b.last = fin;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    repeat (n) step();
  endtask

  vec_t vecs[9];
  int   b0;

  initial begin
    vecs[0] = '{i0: 60,     q0: -40,    thr: 100,   en: 1'b1, trig: 1'b0};
    vecs[1] = '{i0: 60,     q0: -41,    thr: 100,   en: 1'b1, trig: 1'b1};
    vecs[2] = '{i0: -32768, q0: 0,      thr: 32767, en: 1'b1, trig: 1'b1};
    vecs[3] = '{i0: -32768, q0: 0,      thr: 32768, en: 1'b1, trig: 1'b0};
    vecs[4] = '{i0: 0,      q0: 0,      thr: 0,     en: 1'b1, trig: 1'b0};
    vecs[5] = '{i0: 1,      q0: 0,      thr: 0,     en: 1'b1, trig: 1'b1};
    vecs[6] = '{i0: -32768, q0: -32768, thr: 65535, en: 1'b1, trig: 1'b1};
    vecs[7] = '{i0: 32767,  q0: 32767,  thr: 65534, en: 1'b1, trig: 1'b0};
    vecs[8] = '{i0: 1000,   q0: 1000,   thr: 100,   en: 1'b0, trig: 1'b0};

    // Reset state
    #12;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_user", m_user, 0);
    chk("rst_data", m_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_irq", irq, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    set_rdy(1);

    // Trigger threshold table, one-sample frames
    for (int v = 0; v < 9; v++) begin
      enable    = vecs[v].en;
      threshold = 16'(vecs[v].thr);
      frame_len = 16'd1;
      send(vecs[v].i0, vecs[v].q0, 100 + v, -100 - v, vecs[v].trig, 1'b1);
      chk($sformatf("trig_vec%0d", v), m_valid, vecs[v].trig);
      idle(4);
    end
    enable = 1'b1;
    chk("table_drained", exp_q.size(), 0);

    // Equality does not trigger; next sample does; 3-sample frame, samples in DRAIN ignored
    threshold = 16'd100;
    frame_len = 16'd3;
    b0 = beats;
    send(60, -40, 5, 5, 1'b0, 1'b0);
    chk("eq_no_trig", m_valid, 0);
    send(60, -41, 7, 8, 1'b1, 1'b0);
    send(1, 2, 3, 4, 1'b1, 1'b0);
    send(5, 6, 7, 8, 1'b1, 1'b1);
    send(30000, 30000, 11, 12, 1'b0, 1'b0);
    idle(8);
    chk("frame3_beats", beats - b0, 6);
    chk("frame3_drained", exp_q.size(), 0);

    // m_ready toggling: stable outputs under stall, order preserved
    set_rdy(2);
    b0 = beats;
    send(500, 500, 21, 22, 1'b1, 1'b0);
    idle(2);
    send(31, -32, 33, -34, 1'b1, 1'b0);
    idle(2);
    send(-41, 42, -43, 44, 1'b1, 1'b1);
    idle(16);
    chk("toggle_beats", beats - b0, 6);
    chk("toggle_drained", exp_q.size(), 0);
    set_rdy(1);

    // frame_len=0 acts as a single-sample frame
    frame_len = 16'd0;
    b0 = beats;
    send(700, 700, 51, 52, 1'b1, 1'b1);
    idle(5);
    chk("len0_beats", beats - b0, 2);

    // Dropping enable mid-CAPTURE completes the frame without retriggering
    frame_len = 16'd4;
    b0 = beats;
    send(800, 800, 61, 62, 1'b1, 1'b0);
    enable = 1'b0;
    send(900, 900, 63, 64, 1'b1, 1'b0);
    send(901, 901, 65, 66, 1'b1, 1'b0);
    send(902, 902, 67, 68, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) send(2000 + k, 2000, 70, 71, 1'b0, 1'b0);
    idle(4);
    chk("noabort_beats", beats - b0, 8);
    chk("noabort_idle", m_valid, 0);
    chk("noabort_drained", exp_q.size(), 0);
    enable = 1'b1;

    // Reset during CAPTURE after 2 of 5 samples
    set_rdy(0);
    frame_len = 16'd5;
    send(1111, 1111, 81, 82, 1'b1, 1'b0);
    send(83, 84, 85, 86, 1'b1, 1'b0);
    adc_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_last", m_last, 0);
    chk("midrst_user", m_user, 0);
    chk("midrst_data", m_data, 0);
    exp_q.delete();
    step();
    set_rdy(1);
    aresetn = 1'b1;
    b0 = beats;
    send(1200, -1200, 91, 92, 1'b1, 1'b0);
    chk("first_edge_trig", m_valid, 1);
    send(93, 94, 95, 96, 1'b1, 1'b0);
    send(97, 98, 99, 100, 1'b1, 1'b0);
    send(101, 102, 103, 104, 1'b1, 1'b0);
    send(105, 106, 107, 108, 1'b1, 1'b1);
    idle(14);
    chk("fresh_beats", beats - b0, 10);
    chk("fresh_drained", exp_q.size(), 0);

    // Overflow with DEPTH=4, stalled output, frame_len=8
    chk("ovf_clear", overflow, 0);
    set_rdy(0);
    frame_len = 16'd8;
    b0 = beats;
    send(2000, -3000, 1, 2, 1'b1, 1'b0);
    send(3, 4, 5, 6, 1'b1, 1'b0);
    send(7, 8, 9, 10, 1'b1, 1'b0);
    send(11, 12, 13, 14, 1'b1, 1'b0);
    send(-15, -16, -17, -18, 1'b0, 1'b0);
    send(-19, -20, -21, -22, 1'b0, 1'b0);
    idle(2);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_valid", m_valid, 1);
    chk("ovf_head_data", m_data, {16'(-3000), 16'(2000)});
    // Pop of the full FIFO coincides with the second write: both are dropped
    set_rdy(1);
    send(-23, -24, -25, -26, 1'b0, 1'b0);
    send(-27, -28, -29, -30, 1'b0, 1'b0);
    idle(10);
    send(31, 32, 33, 34, 1'b1, 1'b0);
    send(35, 36, 37, 38, 1'b1, 1'b0);
    send(39, 40, 41, 42, 1'b1, 1'b0);
    send(43, 44, 45, 46, 1'b1, 1'b1);
    idle(12);
    chk("ovf_beats", beats - b0, 16);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    aresetn = 1'b0;
    #1;
    chk("ovf_reset", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
